// File: rtl/cordic_grad_sched.sv
// Gradient scheduler: arbitrates four requesters into an external CORDIC, tracks ids through a tag line, buffers results in a FWFT FIFO.
// Build option: define CORDIC_SCHED_FIXED_PRIO_EN for fixed lowest-id priority instead of round-robin.
module cordic_grad_sched #(
  parameter int NREQ       = 4,
  parameter int CORDIC_LAT = 13,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 17
) (
  input  logic                   iclk,
  input  logic                   ireset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_x,
  input  logic [NREQ*DATA_W-1:0] req_y,
  output logic [NREQ-1:0]        req_ready,
  output logic [DATA_W-1:0]      cx,
  output logic [DATA_W-1:0]      cy,
  input  logic [DATA_W-1:0]      cordic_mag,
  input  logic [DATA_W-1:0]      cordic_ang,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DATA_W-1:0]      res_mag,
  output logic [DATA_W-1:0]      res_ang,
  output logic [1:0]             res_id,
  output logic                   busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  logic [1:0]          gnt_id, idx;
  logic                gnt_any, xfer, tail_vld, push, pop;
  logic [CW-1:0]       inflight_q, inflight_d, fifo_cnt_q, fifo_cnt_d;
  logic [CW:0]         occ;
  logic [DATA_W-1:0]   cx_q, cy_q;
  logic [CORDIC_LAT:0] tvld_q;
  logic [1:0]          tid_q [CORDIC_LAT+1];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0]   mem_mag [FIFO_DEPTH];
  logic [DATA_W-1:0]   mem_ang [FIFO_DEPTH];
  logic [1:0]          mem_id  [FIFO_DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Inflight plus buffered results bounds issue so a push never meets a full FIFO
  assign occ = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};

`ifndef CORDIC_SCHED_FIXED_PRIO_EN
  logic [1:0] rr_ptr_q;

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset)   rr_ptr_q <= '0;
    else if (xfer) rr_ptr_q <= gnt_id + 2'd1;
  end
`endif

  // Descending scan so the lowest offset from the start point wins
  always_comb begin
    gnt_any   = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    req_ready = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef CORDIC_SCHED_FIXED_PRIO_EN
      idx = 2'(k);
`else
      idx = rr_ptr_q + 2'(k);
`endif
      if (req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
    if (ireset && gnt_any && (occ < DEPTH_L)) req_ready[gnt_id] = 1'b1;
  end

  assign xfer = |(req_valid & req_ready);

  // Operand register: idle cycles feed zeros into the CORDIC
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      cx_q <= '0;
      cy_q <= '0;
    end else if (xfer) begin
      cx_q <= req_x[gnt_id*DATA_W +: DATA_W];
      cy_q <= req_y[gnt_id*DATA_W +: DATA_W];
    end else begin
      cx_q <= '0;
      cy_q <= '0;
    end
  end

  assign cx = cx_q;
  assign cy = cy_q;

  // Tag line: stage 0 loads with the operand, tail lines up with the CORDIC output register
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) tvld_q <= '0;
    else         tvld_q <= {tvld_q[CORDIC_LAT-1:0], xfer};
  end

  always_ff @(posedge iclk) begin
    tid_q[0] <= gnt_id;
    for (int i = 1; i <= CORDIC_LAT; i++) tid_q[i] <= tid_q[i-1];
  end

  assign tail_vld = tvld_q[CORDIC_LAT];
  assign push     = tail_vld;
  assign pop      = res_valid & res_ready;

  always_comb begin
    inflight_d = inflight_q;
    fifo_cnt_d = fifo_cnt_q;
    if (xfer && !tail_vld)      inflight_d = inflight_q + 1'b1;
    else if (!xfer && tail_vld) inflight_d = inflight_q - 1'b1;
    if (push && !pop)           fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (!push && pop)      fifo_cnt_d = fifo_cnt_q - 1'b1;
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge iclk) begin
    if (push) begin
      mem_mag[wr_ptr_q] <= cordic_mag;
      mem_ang[wr_ptr_q] <= cordic_ang;
      mem_id[wr_ptr_q]  <= tid_q[CORDIC_LAT];
    end
  end

  // Head fields read zero whenever the FIFO is empty
  assign res_valid = (fifo_cnt_q != '0);
  assign res_mag   = res_valid ? mem_mag[rd_ptr_q] : '0;
  assign res_ang   = res_valid ? mem_ang[rd_ptr_q] : '0;
  assign res_id    = res_valid ? mem_id[rd_ptr_q]  : '0;
  assign busy      = (occ != '0);

endmodule

// File: tb/tb_cordic_grad_sched.sv
// Bench for cordic_grad_sched: behavioural CORDIC stand-in plus a queue-based scoreboard of issued requests.
module tb_cordic_grad_sched;
  logic        iclk = 1'b0;
  logic        ireset = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [67:0] req_x = '0, req_y = '0;
  logic [3:0]  req_ready;
  logic [16:0] cx, cy, cordic_mag, cordic_ang;
  logic        res_valid, res_ready = 1'b0, busy;
  logic [16:0] res_mag, res_ang;
  logic [1:0]  res_id;

  always #5 iclk = ~iclk;

  cordic_grad_sched dut (
    .iclk(iclk), .ireset(ireset), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .cx(cx), .cy(cy), .cordic_mag(cordic_mag), .cordic_ang(cordic_ang),
    .res_valid(res_valid), .res_ready(res_ready), .res_mag(res_mag), .res_ang(res_ang),
    .res_id(res_id), .busy(busy)
  );

  function automatic int fmag(input int x, input int y);
    real r;
    r = $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * 1.647;
    return $rtoi(r + 0.5);
  endfunction

  function automatic int fang(input int x, input int y);
    real a;
    int v;
    a = $atan2(real'(y), real'(x)) * 180.0 / 3.14159265358979;
    if (a < 0.0) a = a + 360.0;
    v = $rtoi(a * 64.0 + 0.5);
    if (v >= 23040) v = v - 23040;
    return v;
  endfunction

  // External CORDIC stand-in: 13 register stages, capture stage included, shares the reset
  logic [16:0] pm [13];
  logic [16:0] pa [13];
  always @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      for (int i = 0; i < 13; i++) begin
        pm[i] <= '0;
        pa[i] <= '0;
      end
    end else begin
      pm[0] <= 17'(fmag(int'($signed(cx)), int'($signed(cy))));
      pa[0] <= 17'(fang(int'($signed(cx)), int'($signed(cy))));
      for (int i = 1; i < 13; i++) begin
        pm[i] <= pm[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end
  assign cordic_mag = pm[12];
  assign cordic_ang = pa[12];

  typedef struct {
    int id;
    int mag;
    int ang;
    int avail;
  } ent_t;

  ent_t q[$];
  int checks = 0, errors = 0, cyc = 0, rr = 0, nx = 0, np = 0;
  logic signed [16:0] xs [4];
  logic signed [16:0] ys [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  task automatic rand_xy();
    int t;
    for (int i = 0; i < 4; i++) begin
      t = int'($urandom_range(0, 40000)) - 20000;
      xs[i] = 17'(t);
      t = int'($urandom_range(0, 40000)) - 20000;
      ys[i] = 17'(t);
    end
  endtask

  // One clock: drive, check predicted head/grant, take the edge, advance the model
  task automatic step(input logic [3:0] v, input logic rrdy);
    int   g;
    logic hv;
    ent_t e;
    req_valid = v;
    res_ready = rrdy;
    for (int i = 0; i < 4; i++) begin
      req_x[17*i +: 17] = xs[i];
      req_y[17*i +: 17] = ys[i];
    end
    #1;
    hv = (q.size() > 0) && (q[0].avail <= cyc);
    chk("res_valid", res_valid, hv);
    chk("busy", busy, q.size() != 0);
    if (hv) begin
      chk("res_id", res_id, q[0].id);
      chk("res_mag", res_mag, q[0].mag);
      chk("res_ang", res_ang, q[0].ang);
    end
    g = (v != 0 && q.size() < 16) ? pick(v, rr) : -1;
    chk("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);
    if ((req_ready & req_valid) != 0) nx++;
    if (res_valid && res_ready) np++;
    @(posedge iclk);
    cyc++;
    if (hv && rrdy) void'(q.pop_front());
    if (g >= 0) begin
      e.id    = g;
      e.mag   = fmag(int'(xs[g]), int'(ys[g])) & 17'h1ffff;
      e.ang   = fang(int'(xs[g]), int'(ys[g]));
      e.avail = cyc + 14;
      q.push_back(e);
`ifdef CORDIC_SCHED_FIXED_PRIO_EN
      rr = 0;
`else
      rr = (g + 1) % 4;
`endif
    end
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cx"}, cx, 0);
    chk({tag, "_cy"}, cy, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_mag"}, res_mag, 0);
    chk({tag, "_res_ang"}, res_ang, 0);
    chk({tag, "_res_id"}, res_id, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      xs[i] = '0;
      ys[i] = '0;
    end
    req_valid = 4'hf;
    res_ready = 1'b1;
    repeat (2) @(posedge iclk);
    #1;
    chk_zero("rst");
    ireset    = 1'b1;
    req_valid = '0;

    // Single request 3,4 from requester 0
    xs[0] = 17'sd3;
    ys[0] = 17'sd4;
    step(4'b0001, 1'b1);
    repeat (14) step(4'b0000, 1'b1);
    chk("lat_valid", res_valid, 1);
    chk("lat_id", res_id, 0);
    chk("mag_3_4", (res_mag >= 7 && res_mag <= 9), 1);
    chk("ang_3_4", (res_ang >= 3392 && res_ang <= 3408), 1);
    step(4'b0000, 1'b1);

    // Axis angles, held at the head with res_ready low
    xs[2] = -17'sd5;
    ys[2] = 17'sd0;
    step(4'b0100, 1'b0);
    xs[1] = 17'sd0;
    ys[1] = -17'sd7;
    step(4'b0010, 1'b0);
    repeat (15) step(4'b0000, 1'b0);
    chk("ang_180_id", res_id, 2);
    chk("ang_180", res_ang, 11520);
    step(4'b0000, 1'b1);
    chk("ang_270_id", res_id, 1);
    chk("ang_270", res_ang, 17280);
    step(4'b0000, 1'b1);

    // All four valid, full throughput
    repeat (24) begin
      rand_xy();
      step(4'b1111, 1'b1);
    end
    repeat (16) step(4'b0000, 1'b1);

    // Consumer stalled: issue must stop at FIFO_DEPTH outstanding
    nx = 0;
    repeat (40) begin
      rand_xy();
      step(4'b1111, 1'b0);
    end
    chk("stall_xfers", nx, 16);
    chk("stall_valid", res_valid, 1);
    np = 0;
    repeat (20) step(4'b0000, 1'b1);
    chk("drain_pops", np, 16);

    // Random traffic
    repeat (300) begin
      rand_xy();
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
    repeat (20) step(4'b0000, 1'b1);

    // Reset with results in flight
    repeat (5) begin
      rand_xy();
      step(4'b1111, 1'b1);
    end
    ireset = 1'b0;
    #1;
    chk_zero("midrst");
    q.delete();
    rr = 0;
    @(posedge iclk);
    cyc++;
    #1;
    chk_zero("midrst_edge");
    ireset    = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("first_gnt", req_ready, 4'b0001);
    rand_xy();
    step(4'b1111, 1'b1);
    repeat (20) step(4'b0000, 1'b1);

    // Requesters 0 and 3 competing
    repeat (4) begin
      rand_xy();
      step(4'b1001, 1'b1);
    end
    repeat (20) step(4'b0000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cordic_grad_sched.md
CORDIC_GRAD_SCHED -- requirements
Module: cordic_grad_sched

Interface
REQ-001 Parameter NREQ, 4, number of gradient requesters (fixed; id width 2).
REQ-002 Parameter CORDIC_LAT, 13, register stages from the CORDIC input capture to its output register.
REQ-003 Parameter FIFO_DEPTH, 16, result FIFO entries; SHALL be at least CORDIC_LAT+1.
REQ-004 The clock SHALL be iclk, input, 1 bit, rising-edge.
REQ-005 The reset SHALL be ireset, input, 1 bit, asynchronous, active-low.
REQ-006 req_valid, input, 4, per-requester request pending.
REQ-007 req_x, input, 68, four signed 17-bit x gradients; requester i uses bits [17i+16:17i].
REQ-008 req_y, input, 68, four signed 17-bit y gradients, packed like req_x.
REQ-009 req_ready, output, 4, one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both 1 at a clock edge.
REQ-010 cx, output, 17, signed x operand to the CORDIC sqrt/atan pipeline.
REQ-011 cy, output, 17, signed y operand to the CORDIC pipeline.
REQ-012 cordic_mag, input, 17, CORDIC magnitude output (gain about 1.647, uncompensated).
REQ-013 cordic_ang, input, 17, CORDIC angle output, 64 LSB per degree, range 0..23039.
REQ-014 res_valid, output, 1, result FIFO head is valid.
REQ-015 res_ready, input, 1, consumer accepts the head.
REQ-016 res_mag, output, 17; res_ang, output, 17; res_id, output, 2 -- head fields.
REQ-017 busy, output, 1, high while inflight plus FIFO occupancy is greater than 0.

Function
REQ-018 Issue condition: at least one req_valid is high and inflight + fifo_count < FIFO_DEPTH; otherwise req_ready is all-zero.
REQ-019 Grant is round-robin, searching upward (with wrap) from pointer rr_ptr.
REQ-020 After each transfer, rr_ptr SHALL be set to (granted id + 1) mod 4; with no transfer, rr_ptr is held.
REQ-021 req_ready SHALL be combinational from req_valid, rr_ptr and the occupancy check.
REQ-022 On a transfer edge, cx/cy SHALL register the granted x/y; on an idle edge they SHALL register 0.
REQ-023 A tag delay line of CORDIC_LAT+1 stages (valid, id) SHALL track each operand; the tail aligns with cordic_mag/cordic_ang of that operand.
REQ-024 Latency: a transfer at edge E SHALL produce a FIFO write at edge E+14, with res_valid high after that edge (FIFO empty, first-word-fall-through).
REQ-025 Results SHALL leave in issue order; res_id is the requester id of that issue.
REQ-026 inflight: +1 on transfer, -1 on tail-valid, net 0 when both occur at once; range 0..CORDIC_LAT+1.
REQ-027 FIFO: a pop occurs on res_valid and res_ready; a simultaneous push and pop leaves fifo_count unchanged; a push never finds the FIFO full (guaranteed by REQ-018).
REQ-028 Pointers wrap modulo FIFO_DEPTH; res_valid is 0 when fifo_count is 0.
REQ-029 res_ready held low fills the FIFO, then issue stalls with inflight + fifo_count = FIFO_DEPTH; no result is lost.
REQ-030 Full throughput: one issue per cycle sustained while res_ready is 1.

Reset
REQ-031 Asserting ireset SHALL immediately clear rr_ptr, inflight, the FIFO pointers and count, and all tag valids.
REQ-032 During ireset: cx=0, cy=0, req_ready=0, res_valid=0, res_mag=0, res_ang=0, res_id=0, busy=0.
REQ-033 Reset mid-operation discards all in-flight and buffered results; the CORDIC shares ireset.
REQ-034 The first grant after reset goes to the lowest valid id.

Configuration
REQ-035 Macro CORDIC_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority, lowest valid id wins, rr_ptr not implemented.
- Undefined: round-robin per REQ-019 and REQ-020.

Verification
REQ-036 req0 only, x=3, y=4, res_ready=1 -> after 14 edges: res_id=0, res_mag=8 (±1), res_ang=3400 (±8).
REQ-037 All four valid continuously, round-robin build -> grants 0,1,2,3,0,1...; results return ids in the same order, one per cycle.
REQ-038 req2 x=-5, y=0 -> res_ang=11520; req1 x=0, y=-7 -> res_ang=17280.
REQ-039 res_ready=0, all valid for 40 cycles -> exactly 16 transfers; res_valid high; no overflow; release yields 16 in-order results.
REQ-040 ireset pulsed low with 5 in flight -> outputs zero immediately; no stale res_valid after release; next grant goes to id 0.
REQ-041 FIXED_PRIO build, req0 and req3 valid for 4 cycles -> all four grants go to id 0.
